// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared states, lamp encodings and default phase durations
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_MAIN_GREEN  = 3'd0,
        ST_MAIN_YELLOW = 3'd1,
        ST_ALLRED_A    = 3'd2,
        ST_SIDE_GREEN  = 3'd3,
        ST_SIDE_YELLOW = 3'd4,
        ST_WALK        = 3'd5,
        ST_ALLRED_B    = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam logic [3:0] DEF_MAIN_GREEN_T = 4'd10;
    localparam logic [3:0] DEF_SIDE_GREEN_T = 4'd6;
    localparam logic [3:0] DEF_YELLOW_T     = 4'd3;
    localparam logic [3:0] DEF_ALLRED_T     = 4'd1;
    localparam logic [3:0] DEF_WALK_T       = 4'd7;

endpackage

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - intersection phase sequencer driving an external down-counter timer
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter logic [3:0] MAIN_GREEN_T = DEF_MAIN_GREEN_T,
    parameter logic [3:0] SIDE_GREEN_T = DEF_SIDE_GREEN_T,
    parameter logic [3:0] YELLOW_T     = DEF_YELLOW_T,
    parameter logic [3:0] ALLRED_T     = DEF_ALLRED_T,
    parameter logic [3:0] WALK_T       = DEF_WALK_T
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_car,
    input  logic       walk_req,
    input  logic [3:0] timer_out,
    output logic       timer_load,
    output logic [3:0] timer_init,
    output logic       timer_en,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk
);

    state_t state_q, state_d;
    logic   fresh_q, fresh_d;
    logic   walk_pend_q, walk_pend_d;
    logic   expired;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_MAIN_GREEN;
            fresh_q     <= 1'b1;
            walk_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fresh_q     <= fresh_d;
            walk_pend_q <= walk_pend_d;
        end
    end

    // timer_out is stale during the load cycle, so it only counts once fresh has dropped
    always_comb begin
        state_d     = state_q;
        expired     = ~fresh_q & (timer_out == 4'd0);
        fresh_d     = expired;
        walk_pend_d = (walk_pend_q | walk_req) & (state_q != ST_WALK);
        if (expired) begin
            case (state_q)
                ST_MAIN_GREEN:  state_d = (side_car | walk_pend_q) ? ST_MAIN_YELLOW : ST_MAIN_GREEN;
                ST_MAIN_YELLOW: state_d = ST_ALLRED_A;
                ST_ALLRED_A:    state_d = walk_pend_q ? ST_WALK : ST_SIDE_GREEN;
                ST_SIDE_GREEN:  state_d = ST_SIDE_YELLOW;
                ST_SIDE_YELLOW: state_d = ST_ALLRED_B;
                ST_WALK:        state_d = ST_ALLRED_B;
                default:        state_d = ST_MAIN_GREEN;
            endcase
        end
    end

    always_comb begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
        walk       = 1'b0;
        timer_init = MAIN_GREEN_T;
        case (state_q)
            ST_MAIN_GREEN: begin
                main_light = LAMP_GRN;
                timer_init = MAIN_GREEN_T;
            end
            ST_MAIN_YELLOW: begin
                main_light = LAMP_YEL;
                timer_init = YELLOW_T;
            end
            ST_SIDE_GREEN: begin
                side_light = LAMP_GRN;
                timer_init = SIDE_GREEN_T;
            end
            ST_SIDE_YELLOW: begin
                side_light = LAMP_YEL;
                timer_init = YELLOW_T;
            end
            ST_WALK: begin
                walk       = 1'b1;
                timer_init = WALK_T;
            end
            default: timer_init = ALLRED_T;
        endcase
    end

    assign timer_load = fresh_q;
    assign timer_en   = ~fresh_q;

endmodule
